// File: rtl/glove_uart_rx.sv
// glove_uart_rx: 8N1 serial receiver plus 6-byte glove packet parser feeding catch_game.
// Optional macro GLOVE_TIMEOUT_EN: stale-glove timeout after TIMEOUT_CYCLES without a good packet.
module glove_uart_rx #(
   parameter int unsigned CLK_HZ         = 65000000,
   parameter int unsigned BAUD           = 115200,
   parameter int unsigned TIMEOUT_CYCLES = 6500000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rxd,
   output logic [10:0] glove1x,
   output logic [9:0]  glove1y,
   output logic [10:0] glove2x,
   output logic [9:0]  glove2y,
   output logic        glove1closed,
   output logic        glove2closed,
   output logic        right_hand1,
   output logic        right_hand2,
   output logic        can_catch1,
   output logic        can_catch2,
   output logic        glove1_valid,
   output logic        glove2_valid,
   output logic        update,
   output logic [7:0]  err_count
);
   localparam int unsigned DIV = CLK_HZ / BAUD;
   localparam int unsigned CW  = $clog2(DIV + 1);
   localparam logic [CW-1:0] DIV_FULL = CW'(DIV);
   localparam logic [CW-1:0] DIV_HALF = CW'(DIV / 2);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {P_HUNT, P_B1, P_B2, P_B3, P_B4, P_B5} pk_state_t;

   logic          rx_s1, rx_s2, rx_prev;
   rx_state_t     rx_state, rx_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    bit_idx, bit_idx_next;
   logic [7:0]    shreg, shreg_next;
   logic          byte_valid, byte_valid_next;
   logic          framing_err, framing_err_next;
   logic          tick;

   pk_state_t     pk_state, pk_next;
   logic [7:0]    sh_b1, sh_b2, sh_b3, sh_b4;
   logic          pkt_good, pkt_bad, good1, good2, stale1, stale2;

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rxd;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign tick = (cnt == CW'(1));

   always_comb begin
      rx_next          = rx_state;
      cnt_next         = cnt;
      bit_idx_next     = bit_idx;
      shreg_next       = shreg;
      byte_valid_next  = 1'b0;
      framing_err_next = 1'b0;
      case (rx_state)
         R_IDLE: begin
            if (!rx_s2 && rx_prev) begin
               rx_next  = R_START;
               cnt_next = DIV_HALF;
            end
         end
         R_START: begin
            cnt_next = cnt - CW'(1);
            if (tick) begin
               if (rx_s2) begin
                  rx_next = R_IDLE;
               end else begin
                  rx_next      = R_DATA;
                  cnt_next     = DIV_FULL;
                  bit_idx_next = '0;
               end
            end
         end
         R_DATA: begin
            cnt_next = cnt - CW'(1);
            if (tick) begin
               shreg_next   = {rx_s2, shreg[7:1]};
               cnt_next     = DIV_FULL;
               bit_idx_next = bit_idx + 3'd1;
               if (bit_idx == 3'd7) rx_next = R_STOP;
            end
         end
         R_STOP: begin
            cnt_next = cnt - CW'(1);
            if (tick) begin
               rx_next          = R_IDLE;
               byte_valid_next  = rx_s2;
               framing_err_next = !rx_s2;
            end
         end
         default: rx_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_state    <= R_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         byte_valid  <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         rx_state    <= rx_next;
         cnt         <= cnt_next;
         bit_idx     <= bit_idx_next;
         shreg       <= shreg_next;
         byte_valid  <= byte_valid_next;
         framing_err <= framing_err_next;
      end
   end

   // shreg only shifts in R_DATA, so it still holds the finished byte while byte_valid is high
   always_comb begin
      pk_next  = pk_state;
      pkt_good = 1'b0;
      pkt_bad  = 1'b0;
      if (framing_err) begin
         pk_next = P_HUNT;
      end else if (byte_valid) begin
         case (pk_state)
            P_HUNT:  if (shreg == 8'hA5) pk_next = P_B1;
            P_B1:    pk_next = P_B2;
            P_B2:    pk_next = P_B3;
            P_B3:    pk_next = P_B4;
            P_B4:    pk_next = P_B5;
            P_B5: begin
               pk_next = P_HUNT;
               if (shreg == (sh_b1 ^ sh_b2 ^ sh_b3 ^ sh_b4)) pkt_good = 1'b1;
               else                                         pkt_bad  = 1'b1;
            end
            default: pk_next = P_HUNT;
         endcase
      end
   end

   assign good1 = pkt_good && !sh_b1[7];
   assign good2 = pkt_good &&  sh_b1[7];

   always_ff @(posedge clock) begin
      if (reset) begin
         pk_state <= P_HUNT;
         sh_b1    <= '0;
         sh_b2    <= '0;
         sh_b3    <= '0;
         sh_b4    <= '0;
      end else begin
         pk_state <= pk_next;
         if (byte_valid) begin
            case (pk_state)
               P_B1:    sh_b1 <= shreg;
               P_B2:    sh_b2 <= shreg;
               P_B3:    sh_b3 <= shreg;
               P_B4:    sh_b4 <= shreg;
               default: ;
            endcase
         end
      end
   end

`ifdef GLOVE_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo1, tmo2;

   always_ff @(posedge clock) begin
      if (reset) begin
         tmo1 <= '0;
         tmo2 <= '0;
      end else begin
         if (good1)                            tmo1 <= '0;
         else if (tmo1 != TW'(TIMEOUT_CYCLES)) tmo1 <= tmo1 + TW'(1);
         if (good2)                            tmo2 <= '0;
         else if (tmo2 != TW'(TIMEOUT_CYCLES)) tmo2 <= tmo2 + TW'(1);
      end
   end

   assign stale1 = !good1 && (tmo1 == TW'(TIMEOUT_CYCLES - 1));
   assign stale2 = !good2 && (tmo2 == TW'(TIMEOUT_CYCLES - 1));
`else
   assign stale1 = 1'b0;
   assign stale2 = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         glove1x      <= '0;
         glove1y      <= '0;
         glove2x      <= '0;
         glove2y      <= '0;
         glove1closed <= 1'b0;
         glove2closed <= 1'b0;
         right_hand1  <= 1'b0;
         right_hand2  <= 1'b0;
         can_catch1   <= 1'b0;
         can_catch2   <= 1'b0;
         glove1_valid <= 1'b0;
         glove2_valid <= 1'b0;
         update       <= 1'b0;
         err_count    <= '0;
      end else begin
         update <= pkt_good;
         if (good1) begin
            glove1x      <= {sh_b1[2:0], sh_b2};
            glove1y      <= {sh_b3[1:0], sh_b4};
            glove1closed <= sh_b1[6];
            right_hand1  <= sh_b1[5];
            can_catch1   <= sh_b1[4];
            glove1_valid <= 1'b1;
         end else if (stale1) begin
            glove1closed <= 1'b0;
            glove1_valid <= 1'b0;
         end
         if (good2) begin
            glove2x      <= {sh_b1[2:0], sh_b2};
            glove2y      <= {sh_b3[1:0], sh_b4};
            glove2closed <= sh_b1[6];
            right_hand2  <= sh_b1[5];
            can_catch2   <= sh_b1[4];
            glove2_valid <= 1'b1;
         end else if (stale2) begin
            glove2closed <= 1'b0;
            glove2_valid <= 1'b0;
         end
         if ((pkt_bad || framing_err) && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
      end
   end
endmodule

// File: tb/tb_glove_uart_rx.sv
// Scoreboard bench for glove_uart_rx: expected glove snapshots are queued per packet and
// compared by a monitor on every update strobe; error/no-update cases are checked directly.
module tb_glove_uart_rx;
   localparam int unsigned DIV = 10;

   logic        clock = 1'b0;
   logic        reset, rxd;
   logic [10:0] glove1x, glove2x;
   logic [9:0]  glove1y, glove2y;
   logic        glove1closed, glove2closed, right_hand1, right_hand2;
   logic        can_catch1, can_catch2, glove1_valid, glove2_valid, update;
   logic [7:0]  err_count;

   glove_uart_rx #(.CLK_HZ(1152000), .BAUD(115200), .TIMEOUT_CYCLES(1000)) dut (
      .clock(clock), .reset(reset), .rxd(rxd),
      .glove1x(glove1x), .glove1y(glove1y), .glove2x(glove2x), .glove2y(glove2y),
      .glove1closed(glove1closed), .glove2closed(glove2closed),
      .right_hand1(right_hand1), .right_hand2(right_hand2),
      .can_catch1(can_catch1), .can_catch2(can_catch2),
      .glove1_valid(glove1_valid), .glove2_valid(glove2_valid),
      .update(update), .err_count(err_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [10:0] g1x;
      logic [9:0]  g1y;
      logic [10:0] g2x;
      logic [9:0]  g2y;
      logic c1, r1, k1, v1, c2, r2, k2, v2;
      logic [7:0]  err;
   } snap_t;

   typedef struct packed {
      snap_t v;
      snap_t mask;
   } exp_t;

   snap_t m;
   exp_t  q[$];
   int    checks = 0;
   int    errors = 0;

   function automatic snap_t dut_snap();
      snap_t s;
      s.g1x = glove1x;      s.g1y = glove1y;     s.g2x = glove2x;    s.g2y = glove2y;
      s.c1  = glove1closed; s.r1  = right_hand1; s.k1  = can_catch1; s.v1  = glove1_valid;
      s.c2  = glove2closed; s.r2  = right_hand2; s.k2  = can_catch2; s.v2  = glove2_valid;
      s.err = err_count;
      return s;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // With the timeout build the other glove may go stale meanwhile, so its valid/closed are masked
   task automatic expect_pkt(input logic id);
      exp_t e;
      e.v    = m;
      e.mask = '1;
`ifdef GLOVE_TIMEOUT_EN
      if (id) begin e.mask.v1 = 1'b0; e.mask.c1 = 1'b0; end
      else    begin e.mask.v2 = 1'b0; e.mask.c2 = 1'b0; end
`endif
      q.push_back(e);
   endtask

   always @(negedge clock) begin
      exp_t       e;
      logic [57:0] a, x;
      if (!reset && update) begin
         if (q.size() == 0) begin
            check("spurious update", 64'(update), 64'(0));
         end else begin
            e = q.pop_front();
            a = dut_snap() & e.mask;
            x = e.v & e.mask;
            check("update snapshot", 64'(a), 64'(x));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = fr[i];
         repeat (DIV) @(negedge clock);
      end
      rxd = 1'b1;
      repeat (DIV) @(negedge clock);
   endtask

   task automatic send_packet(input logic [47:0] p);
      for (int i = 5; i >= 0; i--) send_byte(p[i*8 +: 8]);
   endtask

   task automatic drain();
      repeat (5) @(negedge clock);
      check("queue drained", 64'(q.size()), 64'(0));
   endtask

   initial begin
      reset = 1'b1;
      rxd   = 1'b1;
      m     = '0;
      repeat (4) @(negedge clock);
      check("reset state", 64'(dut_snap()), 64'(m));
      reset = 1'b0;
      repeat (5) @(negedge clock);

      // glove 1: x=0x334 y=0x210 catch
      m.g1x = 11'h334; m.g1y = 10'h210; m.c1 = 0; m.r1 = 0; m.k1 = 1; m.v1 = 1;
      expect_pkt(1'b0);
      send_packet(48'hA5_1B_34_02_10_3D);
      drain();

      // glove 2: B1=0xE0 -> closed, right, catch bit (bit4) clear
      m.g2x = 11'h005; m.g2y = 10'h007; m.c2 = 1; m.r2 = 1; m.k2 = 0; m.v2 = 1;
      expect_pkt(1'b1);
      send_packet(48'hA5_E0_05_00_07_E2);
      drain();

      // bad checksum: no update, one error
      send_packet(48'hA5_1B_34_02_10_3C);
      m.err = 8'd1;
      drain();
      check("bad checksum err_count", 64'(err_count), 64'(m.err));
      check("bad checksum glove1x held", 64'(glove1x), 64'(m.g1x));

      // next good packet accepted: glove 1 x=0 y=0x3FF right
      m.g1x = 11'h000; m.g1y = 10'h3FF; m.c1 = 0; m.r1 = 1; m.k1 = 0;
      expect_pkt(1'b0);
      send_packet(48'hA5_20_00_03_FF_DC);
      drain();

      // framing error on B2, remainder of packet discarded
      send_byte(8'hA5); send_byte(8'h1B); send_byte(8'h34, 1'b0);
      send_byte(8'h02); send_byte(8'h10); send_byte(8'h3D);
      m.err = 8'd2;
      drain();
      check("framing err_count", 64'(err_count), 64'(m.err));
      check("framing glove1y held", 64'(glove1y), 64'(m.g1y));

      // junk byte then glove 1 x=0x3FF y=0x1E0 closed catch
      send_byte(8'h12);
      m.g1x = 11'h3FF; m.g1y = 10'h1E0; m.c1 = 1; m.r1 = 0; m.k1 = 1;
      expect_pkt(1'b0);
      send_packet(48'hA5_53_FF_01_E0_4D);
      drain();

      // 0xA5 as payload data for glove 2
      m.g2x = 11'h0A5; m.g2y = 10'h0A5; m.c2 = 0; m.r2 = 0; m.k2 = 1;
      expect_pkt(1'b1);
      send_packet(48'hA5_90_A5_00_A5_90);
      drain();

      // single-cycle low glitch
      rxd = 1'b0; @(negedge clock);
      rxd = 1'b1; repeat (30) @(negedge clock);
      check("glitch err_count", 64'(err_count), 64'(m.err));
      check("glitch glove2x held", 64'(glove2x), 64'(m.g2x));

      // err_count saturation
      for (int i = 0; i < 256; i++) send_byte(8'h00, 1'b0);
      m.err = 8'hFF;
      check("err_count saturates", 64'(err_count), 64'(m.err));

      // reset during B3 (after bits 0..2 of 0x02)
      send_byte(8'hA5); send_byte(8'h1B); send_byte(8'h34);
      rxd = 1'b0; repeat (DIV) @(negedge clock);
      rxd = 1'b0; repeat (DIV) @(negedge clock);
      rxd = 1'b1; repeat (DIV) @(negedge clock);
      rxd = 1'b0; repeat (DIV) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      m = '0;
      check("reset mid-packet", 64'(dut_snap()), 64'(m));
      reset = 1'b0;
      rxd   = 1'b1;
      repeat (30) @(negedge clock);

      // fresh packet after reset, then idle past the timeout
      m.g1x = 11'h3FF; m.g1y = 10'h1E0; m.c1 = 1; m.r1 = 0; m.k1 = 1; m.v1 = 1;
      expect_pkt(1'b0);
      send_packet(48'hA5_53_FF_01_E0_4D);
      drain();
      repeat (1000) @(negedge clock);
`ifdef GLOVE_TIMEOUT_EN
      check("timeout glove1_valid", 64'(glove1_valid), 64'(0));
      check("timeout glove1closed", 64'(glove1closed), 64'(0));
`else
      check("idle glove1_valid", 64'(glove1_valid), 64'(1));
      check("idle glove1closed", 64'(glove1closed), 64'(1));
`endif
      check("idle glove1x held", 64'(glove1x), 64'(m.g1x));
      check("final queue empty", 64'(q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
